ex_mdu: RTL and testbench
=========================

// Module: ex_mdu
// PURPOSE
//  EX-stage multiply/divide unit of the 5-stage MIPS pipeline; sits directly downstream of the ID/EX register.
//  Consumes the decoded MDU op and the forwarded rs/rt data (ID/EX data_rs/data_rt after EX forwarding muxes).
//  Runs multi-cycle MULT/MULTU/DIV/DIVU, owns the architectural HI/LO registers, and serves MFHI/MFLO/MTHI/MTLO.
//  Raises a stall request that the hazard unit uses to freeze PC/IF-ID and bubble ID/EX.
// PARAMETERS
//  MULT_CYCLES  5   busy cycles for MULT/MULTU (>=1)
//  DIV_CYCLES   10  busy cycles for DIV/DIVU (>=1)
// PORTS
//  clk            in   1   clock, rising edge
//  reset          in   1   synchronous, active-high
//  in_mdu_op      in   4   op in EX: NONE/MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO (codes in define.v)
//  in_data_rs     in   32  forwarded rs value
//  in_data_rt     in   32  forwarded rt value
//  out_data       out  32  MFHI->HI, MFLO->LO, else 0; combinational from current HI/LO
//  out_busy       out  1   multi-cycle op in flight
//  out_stall_req  out  1   busy | (in_mdu_op is MULT/MULTU/DIV/DIVU); hazard unit stalls any MDU-class op in ID
//  out_hi         out  32  architectural HI (debug/trace)
//  out_lo         out  32  architectural LO (debug/trace)
// BEHAVIOUR
//  - Reset: HI=0, LO=0, count=0, shadow result=0, out_busy=0; out_data=0 under NONE op. Reset mid-op aborts it; HI/LO=0.
//  - State: down-counter count[4:0]; IDLE when count==0, BUSY otherwise; out_busy=(count!=0).
//  - Start: edge T0 with IDLE and op in {MULT,MULTU,DIV,DIVU}: compute 64-bit result into shadow {res_hi,res_lo},
//    load count=MULT_CYCLES or DIV_CYCLES. Operands sampled at T0 only; later rs/rt changes ignored.
//  - Each edge while BUSY: count-=1. Edge where count 1->0: HI<=res_hi, LO<=res_lo. So out_busy high for
//    exactly N cycles after T0 and new HI/LO visible the cycle out_busy falls.
//  - MULT: signed 32x32->64, {HI,LO}=product. MULTU: unsigned.
//  - DIV: LO=signed quotient (trunc toward 0), HI=remainder (sign of dividend). DIVU: unsigned.
//  - Divide by zero: op still takes DIV_CYCLES busy; HI/LO left unchanged at completion.
//  - DIV 0x80000000 / 0xFFFFFFFF: LO=0x80000000, HI=0 (no trap).
//  - MTHI/MTLO in EX while IDLE: HI (or LO) <= in_data_rs at that edge; visible next cycle.
//  - MFHI/MFLO: out_data reflects HI/LO at current cycle (written back via EX/MEM like an ALU result).
//  - Any MDU op arriving while BUSY is a hazard-unit violation: ignored (no state change); bench asserts never occurs.
//  - Op NONE (bubble from ID/EX stall clear or reset): no state change.
//  - Simultaneous completion edge and new start is impossible (start requires IDLE; stall_req holds it in ID).
// STRUCTURE
//  - define.v (shared): MDU op codes `MDU_NONE..`MDU_MTLO, decoded in the controller from opcode/funct.
//  - Single flat module; no sub-module needed (counter + HI/LO + shadow registers + inline arithmetic).
//  - Arithmetic uses Verilog * and / / % on $signed/unsigned 32-bit operands; latency modelled by counter only.
// TESTING
//  1. MULT rs=0xFFFFFFFD(-3), rt=5 -> out_busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
//  2. MULTU rs=0xFFFFFFFF, rt=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
//  3. DIVU 7/2 -> busy 10 cycles, LO=3, HI=1; DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
//  4. HI=0x11,LO=0x22 then DIV x/0 -> busy 10 cycles, HI=0x11, LO=0x22 unchanged.
//  5. MTHI rs=0xABCD1234, next cycle MFHI -> out_data=0xABCD1234; MTLO 0x5 then MFLO -> 0x5.
//  6. MULT 3*4 started, reset at cycle 2 -> next cycle out_busy=0, HI=LO=0; no late write.

Source files
------------

// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg
//   Shared definitions for the EX-stage multiply/divide unit.
//   - mdu_op_e   : MDU operation codes as decoded by the controller
//   - is_long_op : true for the multi-cycle ops (MULT/MULTU/DIV/DIVU)
//   - is_div_op  : true for DIV/DIVU
//   - mdu_result : 64-bit {hi,lo} result of a multi-cycle op
package ex_mdu_pkg;

   typedef enum logic [3:0] {
      MDU_NONE  = 4'd0,
      MDU_MULT  = 4'd1,
      MDU_MULTU = 4'd2,
      MDU_DIV   = 4'd3,
      MDU_DIVU  = 4'd4,
      MDU_MFHI  = 4'd5,
      MDU_MFLO  = 4'd6,
      MDU_MTHI  = 4'd7,
      MDU_MTLO  = 4'd8
   } mdu_op_e;

   function automatic logic is_long_op(input logic [3:0] op);
      return (op == MDU_MULT) || (op == MDU_MULTU) ||
             (op == MDU_DIV)  || (op == MDU_DIVU);
   endfunction

   function automatic logic is_div_op(input logic [3:0] op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

   // {hi,lo} for MULT/MULTU (product) and DIV/DIVU ({remainder,quotient}).
   // A zero divisor is replaced by 1 only to keep the arithmetic defined;
   // the caller discards that result.
   function automatic logic [63:0] mdu_result(input logic [3:0]  op,
                                              input logic [31:0] rs,
                                              input logic [31:0] rt);
      logic signed [63:0] prod_s;
      logic        [63:0] prod_u;
      logic        [31:0] dvs;
      logic signed [31:0] quo_s;
      logic signed [31:0] rem_s;
      logic        [31:0] quo_u;
      logic        [31:0] rem_u;
      logic               ovf;
      logic        [63:0] res;

      prod_s = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
      prod_u = {32'd0, rs} * {32'd0, rt};
      dvs    = (rt == 32'd0) ? 32'd1 : rt;
      // Most-negative / -1 overflows the 32-bit quotient; wraps to itself, rem 0.
      ovf    = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);
      if (ovf) begin
         quo_s = 32'sh8000_0000;
         rem_s = 32'sd0;
      end else begin
         quo_s = $signed(rs) / $signed(dvs);
         rem_s = $signed(rs) % $signed(dvs);
      end
      quo_u = rs / dvs;
      rem_u = rs % dvs;

      case (op)
         MDU_MULT:  res = prod_s;
         MDU_MULTU: res = prod_u;
         MDU_DIV:   res = {rem_s, quo_s};
         MDU_DIVU:  res = {rem_u, quo_u};
         default:   res = 64'd0;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/ex_mdu_if.sv
// ex_mdu_if
//   Bundle between the ID/EX stage (forwarded operands + decoded op) and
//   the EX-stage multiply/divide unit.
//   master : pipeline side (drives op/operands, reads result/busy/stall)
//   slave  : ex_mdu side
//   in_mdu_op[3:0], in_data_rs[31:0], in_data_rt[31:0]   -> unit
//   out_data[31:0], out_busy, out_stall_req, out_hi/lo   <- unit
interface ex_mdu_if;
   logic [3:0]  in_mdu_op;
   logic [31:0] in_data_rs;
   logic [31:0] in_data_rt;
   logic [31:0] out_data;
   logic        out_busy;
   logic        out_stall_req;
   logic [31:0] out_hi;
   logic [31:0] out_lo;

   modport master (
      output in_mdu_op, in_data_rs, in_data_rt,
      input  out_data, out_busy, out_stall_req, out_hi, out_lo
   );

   modport slave (
      input  in_mdu_op, in_data_rs, in_data_rt,
      output out_data, out_busy, out_stall_req, out_hi, out_lo
   );
endinterface

// File: rtl/ex_mdu.sv
// ex_mdu
//   EX-stage multiply/divide unit. Owns architectural HI/LO, runs
//   MULT/MULTU/DIV/DIVU with a fixed counter-modelled latency and serves
//   MFHI/MFLO/MTHI/MTLO.
//   Ports:
//     clk    - rising-edge clock
//     reset  - synchronous, active-high; aborts any op, clears HI/LO
//     mdu    - ex_mdu_if.slave (op/operands in; data, busy, stall, HI/LO out)
//   Parameters:
//     MULT_CYCLES - busy cycles for MULT/MULTU (1..31)
//     DIV_CYCLES  - busy cycles for DIV/DIVU   (1..31)
module ex_mdu
   import ex_mdu_pkg::*;
#(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic      clk,
   input  logic      reset,
   ex_mdu_if.slave   mdu
);

   localparam logic [4:0] MULT_CNT = 5'(MULT_CYCLES);
   localparam logic [4:0] DIV_CNT  = 5'(DIV_CYCLES);

   logic [4:0]  count_q,  count_d;
   logic [31:0] hi_q,     hi_d;
   logic [31:0] lo_q,     lo_d;
   logic [31:0] res_hi_q, res_hi_d;
   logic [31:0] res_lo_q, res_lo_d;
   logic        res_wr_q, res_wr_d;

   logic        idle;
   logic        start;
   logic [63:0] result;

   assign idle   = (count_q == 5'd0);
   assign start  = idle && is_long_op(mdu.in_mdu_op);
   assign result = mdu_result(mdu.in_mdu_op, mdu.in_data_rs, mdu.in_data_rt);

   always_comb begin
      count_d  = count_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      res_hi_d = res_hi_q;
      res_lo_d = res_lo_q;
      res_wr_d = res_wr_q;

      if (start) begin
         res_hi_d = result[63:32];
         res_lo_d = result[31:0];
         // Divide by zero still occupies the unit but leaves HI/LO alone.
         res_wr_d = !(is_div_op(mdu.in_mdu_op) && (mdu.in_data_rt == 32'd0));
         count_d  = is_div_op(mdu.in_mdu_op) ? DIV_CNT : MULT_CNT;
      end else if (!idle) begin
         // Any op presented while busy is ignored; only the countdown runs.
         count_d = count_q - 5'd1;
         if ((count_q == 5'd1) && res_wr_q) begin
            hi_d = res_hi_q;
            lo_d = res_lo_q;
         end
      end else if (mdu.in_mdu_op == MDU_MTHI) begin
         hi_d = mdu.in_data_rs;
      end else if (mdu.in_mdu_op == MDU_MTLO) begin
         lo_d = mdu.in_data_rs;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count_q  <= 5'd0;
         hi_q     <= 32'd0;
         lo_q     <= 32'd0;
         res_hi_q <= 32'd0;
         res_lo_q <= 32'd0;
         res_wr_q <= 1'b0;
      end else begin
         count_q  <= count_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         res_hi_q <= res_hi_d;
         res_lo_q <= res_lo_d;
         res_wr_q <= res_wr_d;
      end
   end

   always_comb begin
      mdu.out_data = 32'd0;
      case (mdu.in_mdu_op)
         MDU_MFHI: mdu.out_data = hi_q;
         MDU_MFLO: mdu.out_data = lo_q;
         default:  mdu.out_data = 32'd0;
      endcase
   end

   assign mdu.out_busy      = !idle;
   assign mdu.out_stall_req = !idle || is_long_op(mdu.in_mdu_op);
   assign mdu.out_hi        = hi_q;
   assign mdu.out_lo        = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu
//   Self-checking bench for ex_mdu: directed cases followed by randomized
//   op sequences compared against a plain-arithmetic HI/LO model.
module tb_ex_mdu;
   import ex_mdu_pkg::*;

   localparam int MC = 5;
   localparam int DC = 10;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   ex_mdu_if bus ();

   ex_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk   (clk),
      .reset (reset),
      .mdu   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [31:0] m_hi = 32'd0;
   logic [31:0] m_lo = 32'd0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference semantics of the architectural HI/LO update.
   task automatic model_apply(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      int                ia, ib;
      longint            a, b, q, r;
      longint unsigned   ua, ub, p;
      logic [63:0]       v;
      ia = rs;
      ib = rt;
      a  = ia;
      b  = ib;
      ua = {32'd0, rs};
      ub = {32'd0, rt};
      case (op)
         MDU_MULT: begin
            v = a * b;
            m_hi = v[63:32];
            m_lo = v[31:0];
         end
         MDU_MULTU: begin
            p = ua * ub;
            v = p;
            m_hi = v[63:32];
            m_lo = v[31:0];
         end
         MDU_DIV: if (rt != 0) begin
            q = a / b;
            r = a % b;
            v = q;
            m_lo = v[31:0];
            v = r;
            m_hi = v[31:0];
         end
         MDU_DIVU: if (rt != 0) begin
            m_lo = rs / rt;
            m_hi = rs % rt;
         end
         MDU_MTHI: m_hi = rs;
         MDU_MTLO: m_lo = rs;
         default: ;
      endcase
   endtask

   task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      logic        long_op;
      int          n;
      logic [31:0] old_hi, old_lo;
      long_op = (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
      n       = ((op == MDU_DIV) || (op == MDU_DIVU)) ? DC : MC;
      old_hi  = m_hi;
      old_lo  = m_lo;

      @(negedge clk);
      bus.in_mdu_op  = op;
      bus.in_data_rs = rs;
      bus.in_data_rt = rt;
      #1;
      chk("stall_req_issue", {31'd0, bus.out_stall_req}, {31'd0, long_op});
      if (op == MDU_MFHI)      chk("mfhi_data", bus.out_data, m_hi);
      else if (op == MDU_MFLO) chk("mflo_data", bus.out_data, m_lo);
      else                     chk("data_zero", bus.out_data, 32'd0);

      @(posedge clk);
      #1;
      // Later operand changes must not affect an op already started.
      bus.in_mdu_op  = MDU_NONE;
      bus.in_data_rs = $urandom;
      bus.in_data_rt = $urandom;

      if (long_op) begin
         for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("busy_high", {31'd0, bus.out_busy}, 32'd1);
            chk("stall_busy", {31'd0, bus.out_stall_req}, 32'd1);
            if (i == n - 1) begin
               chk("hi_before_done", bus.out_hi, old_hi);
               chk("lo_before_done", bus.out_lo, old_lo);
            end
         end
         @(negedge clk);
         chk("busy_low", {31'd0, bus.out_busy}, 32'd0);
      end else begin
         @(negedge clk);
      end
      model_apply(op, rs, rt);
      chk("hi", bus.out_hi, m_hi);
      chk("lo", bus.out_lo, m_lo);
   endtask

   initial begin
      logic [3:0]  op;
      logic [31:0] rs, rt;
      int          sel;

      reset          = 1'b1;
      bus.in_mdu_op  = MDU_NONE;
      bus.in_data_rs = 32'd0;
      bus.in_data_rt = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy",  {31'd0, bus.out_busy}, 32'd0);
      chk("rst_stall", {31'd0, bus.out_stall_req}, 32'd0);
      chk("rst_hi",    bus.out_hi, 32'd0);
      chk("rst_lo",    bus.out_lo, 32'd0);
      chk("rst_data",  bus.out_data, 32'd0);
      reset = 1'b0;

      // Directed cases
      run_op(MDU_MULT,  32'hFFFF_FFFD, 32'd5);
      chk("mult_hi_const", bus.out_hi, 32'hFFFF_FFFF);
      chk("mult_lo_const", bus.out_lo, 32'hFFFF_FFF1);
      run_op(MDU_MULTU, 32'hFFFF_FFFF, 32'd2);
      chk("multu_hi_const", bus.out_hi, 32'h0000_0001);
      chk("multu_lo_const", bus.out_lo, 32'hFFFF_FFFE);
      run_op(MDU_DIVU,  32'd7, 32'd2);
      chk("divu_lo_const", bus.out_lo, 32'd3);
      chk("divu_hi_const", bus.out_hi, 32'd1);
      run_op(MDU_DIV,   32'hFFFF_FFF9, 32'd2);
      chk("div_lo_const", bus.out_lo, 32'hFFFF_FFFD);
      chk("div_hi_const", bus.out_hi, 32'hFFFF_FFFF);
      run_op(MDU_MTHI,  32'h11, 32'd0);
      run_op(MDU_MTLO,  32'h22, 32'd0);
      run_op(MDU_DIV,   32'd1234, 32'd0);
      chk("div0_hi_const", bus.out_hi, 32'h11);
      chk("div0_lo_const", bus.out_lo, 32'h22);
      run_op(MDU_DIVU,  32'd99, 32'd0);
      run_op(MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF);
      chk("divovf_lo_const", bus.out_lo, 32'h8000_0000);
      chk("divovf_hi_const", bus.out_hi, 32'd0);
      run_op(MDU_MTHI,  32'hABCD_1234, 32'd0);
      run_op(MDU_MFHI,  32'd0, 32'd0);
      run_op(MDU_MTLO,  32'h5, 32'd0);
      run_op(MDU_MFLO,  32'd0, 32'd0);

      // Reset in the middle of a MULT aborts it with no late write.
      @(negedge clk);
      bus.in_mdu_op  = MDU_MULT;
      bus.in_data_rs = 32'd3;
      bus.in_data_rt = 32'd4;
      @(posedge clk);
      #1;
      bus.in_mdu_op = MDU_NONE;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_busy", {31'd0, bus.out_busy}, 32'd0);
      chk("abort_hi",   bus.out_hi, 32'd0);
      chk("abort_lo",   bus.out_lo, 32'd0);
      reset = 1'b0;
      m_hi  = 32'd0;
      m_lo  = 32'd0;
      repeat (MC + 3) @(negedge clk);
      chk("abort_no_late_hi", bus.out_hi, 32'd0);
      chk("abort_no_late_lo", bus.out_lo, 32'd0);

      // Randomized op stream
      for (int k = 0; k < 80; k++) begin
         op  = 4'($urandom_range(0, 8));
         rs  = $urandom;
         rt  = $urandom;
         sel = $urandom_range(0, 9);
         if (sel == 0)      rt = 32'd0;
         else if (sel == 1) begin rs = 32'h8000_0000; rt = 32'hFFFF_FFFF; end
         else if (sel == 2) rt = 32'($urandom_range(1, 16));
         else if (sel == 3) rt = -32'($urandom_range(1, 16));
         run_op(op, rs, rt);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
